chrono_cpu: RTL

Parametrised, self-sequencing 3-bit chronospatial processor: program memory, instruction pointer, A/B/C registers, combo/literal operand decode and all eight opcodes in one block. It supersedes the fixed 48-bit execute datapath and adds width/depth parameters, a load port, start/done control, a backpressured output stream and illegal-operand trapping. It sits between the host/test interface, which loads the program and initial registers, and the output sink.

---
 rtl/chrono_cpu.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/chrono_cpu.sv
// chrono_cpu: self-sequencing 3-bit chronospatial processor with program
// memory, A/B/C registers, combo/literal operand decode and all 8 opcodes.
// Ports: clk/rst_n; prog_we/addr/data/len load port; a/b/c_init, start;
// busy/done/err status; out_valid/out_data/out_ready output stream;
// reg_a_o/reg_b_o/reg_c_o/ip_o live state.
// Optional macro CHRONO_STEP_LIMIT_EN: trap after STEP_LIMIT executions.
module chrono_cpu #(
  parameter int REG_W      = 48,
  parameter int PROG_DEPTH = 16,
  parameter int STEP_LIMIT = 65535,
  localparam int AW        = $clog2(PROG_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [2:0]       prog_data,
  input  logic [AW:0]      prog_len,
  input  logic [REG_W-1:0] a_init,
  input  logic [REG_W-1:0] b_init,
  input  logic [REG_W-1:0] c_init,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             out_valid,
  output logic [2:0]       out_data,
  input  logic             out_ready,
  output logic [REG_W-1:0] reg_a_o,
  output logic [REG_W-1:0] reg_b_o,
  output logic [REG_W-1:0] reg_c_o,
  output logic [AW-1:0]    ip_o
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    OUT_WAIT,
    DONE,
    ERR
  } state_t;

  localparam logic [REG_W-1:0] W_LIM = REG_W'(REG_W);

  state_t state, state_d;

  logic [2:0]       mem [PROG_DEPTH];
  logic [REG_W-1:0] a, a_d;
  logic [REG_W-1:0] b, b_d;
  logic [REG_W-1:0] c, c_d;
  logic [AW:0]      ip, ip_d;
  logic             done_d, err_d;
  logic             ov_d;
  logic [2:0]       od_d;

  logic [2:0]       opc, opr;
  logic [REG_W-1:0] lit, combo;
  logic [AW+1:0]    ip_p1;
  logic             halt, uses_combo, trap;
  logic             step_hit;
  logic             idle_like;

  function automatic logic [REG_W-1:0] shr(
    input logic [REG_W-1:0] v,
    input logic [REG_W-1:0] n
  );
    if (n >= W_LIM) return '0;
    return v >> n;
  endfunction

  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
  assign busy      = (state == RUN) || (state == OUT_WAIT);

  // ip carries an extra bit so ip + 2 and jnz targets never alias low
  // addresses; the halt test is done one bit wider again for ip + 1.
  assign ip_p1 = {1'b0, ip} + (AW+2)'(1);
  assign halt  = ip_p1 >= {1'b0, prog_len};

  // Reads beyond the array only happen when halt is true and are unused.
  assign opc = mem[ip[AW-1:0]];
  assign opr = mem[ip[AW-1:0] + AW'(1)];
  assign lit = REG_W'(opr);

  always_comb begin
    combo = lit;
    case (opr)
      3'd4:    combo = a;
      3'd5:    combo = b;
      3'd6:    combo = c;
      default: combo = lit;
    endcase
  end

  assign uses_combo = opc inside {3'd0, 3'd2, 3'd5, 3'd6, 3'd7};
  assign trap       = uses_combo && (opr == 3'd7);

`ifdef CHRONO_STEP_LIMIT_EN
  localparam int SW = $clog2(STEP_LIMIT + 1);
  logic [SW-1:0] steps, steps_d;
  assign step_hit = (steps == SW'(STEP_LIMIT));
`else
  // Counter compiled out; a negative limit can never match.
  assign step_hit = (STEP_LIMIT < 0);
`endif

  always_comb begin
    state_d = state;
    a_d     = a;
    b_d     = b;
    c_d     = c;
    ip_d    = ip;
    done_d  = done;
    err_d   = err;
    ov_d    = out_valid;
    od_d    = out_data;
`ifdef CHRONO_STEP_LIMIT_EN
    steps_d = steps;
`endif
    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          a_d     = a_init;
          b_d     = b_init;
          c_d     = c_init;
          ip_d    = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = RUN;
`ifdef CHRONO_STEP_LIMIT_EN
          steps_d = '0;
`endif
        end
      end
      RUN: begin
        if (halt) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if (step_hit || trap) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          ip_d = ip + (AW+1)'(2);
`ifdef CHRONO_STEP_LIMIT_EN
          steps_d = steps + SW'(1);
`endif
          case (opc)
            3'd0: a_d = shr(a, combo);
            3'd1: b_d = b ^ lit;
            3'd2: b_d = REG_W'(combo[2:0]);
            3'd3: if (a != '0) ip_d = (AW+1)'(opr);
            3'd4: b_d = b ^ c;
            3'd5: begin
              ov_d    = 1'b1;
              od_d    = combo[2:0];
              state_d = OUT_WAIT;
            end
            3'd6: b_d = shr(a, combo);
            default: c_d = shr(a, combo);
          endcase
        end
      end
      OUT_WAIT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      ip        <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_d;
      a         <= a_d;
      b         <= b_d;
      c         <= c_d;
      ip        <= ip_d;
      done      <= done_d;
      err       <= err_d;
      out_valid <= ov_d;
      out_data  <= od_d;
    end
  end

`ifdef CHRONO_STEP_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) steps <= '0;
    else        steps <= steps_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PROG_DEPTH; i++) mem[i] <= '0;
    end else if (prog_we && idle_like) begin
      mem[prog_addr] <= prog_data;
    end
  end

  assign reg_a_o = a;
  assign reg_b_o = b;
  assign reg_c_o = c;
  assign ip_o    = ip[AW-1:0];

endmodule
